// File: rtl/cardinal_nic_fifo.sv
// Cardinal NIC with configurable-depth input/output FIFOs, occupancy status and sticky flags.

// Generic circular-buffer FIFO; the registered count drives full/empty.
// Latency: a push is visible at head_dat one cycle later (no fall-through).
// Backpressure: a push when full or a pop when empty is ignored; the caller flags drops.
module cardinal_nic_fifo_buf #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push_vld,
  input  logic [W-1:0]                   push_dat,
  input  logic                           pop_vld,
  output logic [W-1:0]                   head_dat,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push_vld && (count != FULL_CNT);
  assign do_pop   = pop_vld && (count != '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// NIC between a memory-mapped processor port and a mesh router port.
// Latency: processor reads return on d_out one cycle after the access; sends are combinational.
// Backpressure: net_ri drops when the input FIFO is full; sends wait on net_ro and polarity.
module cardinal_nic_fifo #(
  parameter int       DATA_W    = 64,
  parameter int       IN_DEPTH  = 4,
  parameter int       OUT_DEPTH = 4,
  parameter bit       SEND_POL  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicEnWr,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity
);
  localparam int CW_IN  = $clog2(IN_DEPTH + 1);
  localparam int CW_OUT = $clog2(OUT_DEPTH + 1);
  localparam logic [CW_IN-1:0]  IN_FULL  = CW_IN'(IN_DEPTH);
  localparam logic [CW_OUT-1:0] OUT_FULL = CW_OUT'(OUT_DEPTH);

  logic [CW_IN-1:0]  in_count;
  logic [CW_OUT-1:0] out_count;
  logic [DATA_W-1:0] in_head_dat;
  logic [DATA_W-1:0] out_head_dat;
  logic              in_ovf;
  logic              out_drop;
  logic              proc_rd;
  logic              proc_wr;
  logic              in_pop_vld;
  logic              out_push_vld;
  logic              in_ovf_set;
  logic              out_drop_set;
  logic [DATA_W-1:0] in_status;
  logic [DATA_W-1:0] out_status;
  logic [DATA_W-1:0] d_out_nxt;

  assign proc_rd      = nicEn && !nicEnWr;
  assign proc_wr      = nicEn && nicEnWr;
  assign in_pop_vld   = proc_rd && (addr == 2'b00);
  assign out_push_vld = proc_wr && (addr == 2'b10);
  assign in_ovf_set   = net_si && (in_count == IN_FULL);
  assign out_drop_set = out_push_vld && (out_count == OUT_FULL);

  assign net_ri = (in_count != IN_FULL);
  assign net_so = (out_count != '0) && net_ro && (net_polarity == SEND_POL);
  assign net_do = net_so ? out_head_dat : '0;

  cardinal_nic_fifo_buf #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (net_si),
    .push_dat (net_di),
    .pop_vld  (in_pop_vld),
    .head_dat (in_head_dat),
    .count    (in_count)
  );

  cardinal_nic_fifo_buf #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (out_push_vld),
    .push_dat (d_in),
    .pop_vld  (net_so),
    .head_dat (out_head_dat),
    .count    (out_count)
  );

  always_comb begin
    in_status               = '0;
    in_status[0]            = (in_count != '0);
    in_status[1]            = in_ovf;
    in_status[8 +: CW_IN]   = in_count;
    out_status              = '0;
    out_status[0]           = (out_count == OUT_FULL);
    out_status[1]           = out_drop;
    out_status[8 +: CW_OUT] = out_count;
  end

  always_comb begin
    d_out_nxt = '0;
    if (proc_rd) begin
      case (addr)
        2'b00:   d_out_nxt = (in_count != '0) ? in_head_dat : '0;
        2'b01:   d_out_nxt = in_status;
        2'b11:   d_out_nxt = out_status;
        default: d_out_nxt = '0;
      endcase
    end
  end

  // A status read clears its sticky flag, but a fresh event on the same edge keeps it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_out    <= '0;
      in_ovf   <= 1'b0;
      out_drop <= 1'b0;
    end else begin
      d_out <= d_out_nxt;
      if (in_ovf_set)                        in_ovf <= 1'b1;
      else if (proc_rd && (addr == 2'b01))   in_ovf <= 1'b0;
      if (out_drop_set)                      out_drop <= 1'b1;
      else if (proc_rd && (addr == 2'b11))   out_drop <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cardinal_nic_fifo.sv
// Directed self-checking bench for cardinal_nic_fifo (DATA_W=64, depths 4, SEND_POL=1).
module tb_cardinal_nic_fifo;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicEnWr;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;

  int checks = 0;
  int errors = 0;

  cardinal_nic_fifo #(.DATA_W(64), .IN_DEPTH(4), .OUT_DEPTH(4), .SEND_POL(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicEnWr      (nicEnWr),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a);
    nicEn = 1'b1; nicEnWr = 1'b0; addr = a;
    tick();
    nicEn = 1'b0;
  endtask

  task automatic wr(input logic [63:0] dat);
    nicEn = 1'b1; nicEnWr = 1'b1; addr = 2'b10; d_in = dat;
    tick();
    nicEn = 1'b0; nicEnWr = 1'b0;
  endtask

  task automatic net_push(input logic [63:0] dat);
    net_si = 1'b1; net_di = dat;
    tick();
    net_si = 1'b0;
  endtask

  localparam logic [63:0] A1 = 64'hA1A1_0000_0000_0001, A2 = 64'hA2A2_0000_0000_0002;
  localparam logic [63:0] A3 = 64'hA3A3_0000_0000_0003, A4 = 64'hA4A4_0000_0000_0004;
  localparam logic [63:0] A5 = 64'hA5A5_0000_0000_0005;
  localparam logic [63:0] B1 = 64'hB1B1_1111_0000_0001, B2 = 64'hB2B2_2222_0000_0002;
  localparam logic [63:0] B3 = 64'hB3B3_3333_0000_0003;

  // Polarity-gating vectors: per cycle polarity, whether Bn is written, expected so/do.
  logic [6:0]  pol_vec  = 7'b0101010;
  logic [6:0]  exp_so   = 7'b0101010;
  logic [63:0] wr_dat [7];
  logic [6:0]  wr_en    = 7'b0000111;
  logic [63:0] exp_do [7];

  initial begin
    reset = 1'b1; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicEnWr = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
    wr_dat = '{B1, B2, B3, 64'h0, 64'h0, 64'h0, 64'h0};
    exp_do = '{64'h0, B1, 64'h0, B2, 64'h0, B3, 64'h0};

    // Reset with activity on both ports
    for (int i = 0; i < 2; i++) begin
      net_si = i[0]; net_di = 64'hDEAD_0000_0000_0000 | 64'(i);
      nicEn = ~i[0]; nicEnWr = 1'b0; addr = 2'b00;
      tick();
    end
    reset = 1'b0; net_si = 1'b0; nicEn = 1'b0;
    net_ro = 1'b1; net_polarity = 1'b1;
    #1;
    check("rst_ri", 64'(net_ri), 64'd1);
    check("rst_so", 64'(net_so), 64'd0);
    check("rst_do", net_do, 64'd0);
    check("rst_dout", d_out, 64'd0);
    net_ro = 1'b0; net_polarity = 1'b0;
    rd(2'b01); check("rst_in_status", d_out, 64'h0);
    rd(2'b11); check("rst_out_status", d_out, 64'h0);

    // Input fill and overflow
    net_push(A1); net_push(A2); net_push(A3);
    check("ri_before_full", 64'(net_ri), 64'd1);
    net_push(A4);
    check("ri_full", 64'(net_ri), 64'd0);
    net_push(A5);
    rd(2'b01); check("in_status_ovf", d_out, 64'h403);
    rd(2'b01); check("in_status_ovf_clr", d_out, 64'h401);

    // Input order and empty read
    rd(2'b00); check("pop_a1", d_out, A1);
    check("ri_after_pop", 64'(net_ri), 64'd1);
    rd(2'b00); check("pop_a2", d_out, A2);
    rd(2'b00); check("pop_a3", d_out, A3);
    rd(2'b00); check("pop_a4", d_out, A4);
    rd(2'b00); check("pop_empty", d_out, 64'h0);
    rd(2'b01); check("in_status_empty", d_out, 64'h0);
    rd(2'b10); check("rd_out_data_zero", d_out, 64'h0);

    // Output polarity gating
    net_ro = 1'b1;
    for (int c = 0; c < 7; c++) begin
      net_polarity = pol_vec[c];
      if (wr_en[c]) begin
        nicEn = 1'b1; nicEnWr = 1'b1; addr = 2'b10; d_in = wr_dat[c];
      end
      #1;
      check($sformatf("pol_so_c%0d", c), 64'(net_so), 64'(exp_so[c]));
      check($sformatf("pol_do_c%0d", c), net_do, exp_do[c]);
      tick();
      nicEn = 1'b0; nicEnWr = 1'b0;
    end

    // Output full, drop, send while a write is dropped
    net_ro = 1'b0; net_polarity = 1'b1;
    for (int k = 1; k <= 5; k++) wr(64'hC000_0000_0000_0000 | 64'(k));
    rd(2'b11); check("out_status_full_drop", d_out, 64'h403);
    check("so_blocked_ro", 64'(net_so), 64'd0);
    net_ro = 1'b1;
    nicEn = 1'b1; nicEnWr = 1'b1; addr = 2'b10; d_in = 64'hC000_0000_0000_0006;
    #1;
    check("full_send_so", 64'(net_so), 64'd1);
    check("full_send_do", net_do, 64'hC000_0000_0000_0001);
    tick();
    nicEn = 1'b0; nicEnWr = 1'b0; net_ro = 1'b0;
    rd(2'b11); check("out_status_after", d_out, 64'h302);
    net_ro = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      #1;
      check($sformatf("drain_c%0d", k), net_do, 64'hC000_0000_0000_0000 | 64'(k));
      tick();
    end
    #1;
    check("drain_empty_so", 64'(net_so), 64'd0);
    net_ro = 1'b0;

    // Simultaneous push/pop on the input FIFO
    net_push(64'hD1); net_push(64'hD2);
    net_si = 1'b1; net_di = 64'hD3;
    rd(2'b00);
    net_si = 1'b0;
    check("pushpop_oldest", d_out, 64'hD1);
    rd(2'b01); check("pushpop_count", d_out, 64'h201);

    // Mid-operation reset with three packets in each FIFO
    net_push(64'hD4);
    wr(64'hE1); wr(64'hE2); wr(64'hE3);
    rd(2'b01); check("pre_rst_in", d_out, 64'h301);
    rd(2'b11); check("pre_rst_out", d_out, 64'h300);
    reset = 1'b1; net_si = 1'b1; net_di = 64'hF0;
    tick();
    reset = 1'b0; net_si = 1'b0; net_ro = 1'b1; net_polarity = 1'b1;
    #1;
    check("mid_rst_so", 64'(net_so), 64'd0);
    check("mid_rst_ri", 64'(net_ri), 64'd1);
    check("mid_rst_dout", d_out, 64'h0);
    net_ro = 1'b0;
    rd(2'b01); check("mid_rst_in_status", d_out, 64'h0);
    rd(2'b11); check("mid_rst_out_status", d_out, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cardinal_nic_fifo.md
Name: cardinal_nic_fifo

Overview:
Parametrised successor to the single-entry Cardinal NIC, sitting between a processor's memory-mapped port and its mesh router port.
- Replaces the one-packet input/output buffers with configurable-depth FIFOs.
- Adds occupancy reporting and sticky overflow/drop flags.
- Adds a selectable send polarity.
- Keeps the 2-bit register map and the router handshake (si/ri, so/ro, polarity).

Parameters:
DATA_W, 64, packet and processor data width
IN_DEPTH, 4, input FIFO entries (power of two, >=2)
OUT_DEPTH, 4, output FIFO entries (power of two, >=2)
SEND_POL, 1, net_polarity value on which the output FIFO may send

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
addr  in  2  register select: 00 in-data, 01 in-status, 10 out-data, 11 out-status
d_in  in  DATA_W  processor write data
d_out  out  DATA_W  processor read data (registered)
nicEn  in  1  access enable
nicEnWr  in  1  1=write, 0=read (valid with nicEn)
net_si  in  1  router offers packet on net_di
net_ri  out  1  NIC can accept a packet
net_di  in  DATA_W  incoming packet
net_so  out  1  NIC sends packet this cycle
net_ro  in  1  router can accept
net_do  out  DATA_W  outgoing packet (0 when net_so=0)
net_polarity  in  1  router cycle polarity

Behaviour:
- Reset (sync): both FIFOs empty, pointers/counts 0, sticky flags 0, d_out=0. Combinationally this gives net_ri=1, net_so=0, net_do=0.
- Status word, in-status (addr 01):
  - bit0 = in_count!=0
  - bit1 = in_ovf sticky
  - bits[8 +: CW_IN] = in_count
  - others 0
  - CW = $clog2(DEPTH+1).
- Status word, out-status (addr 11):
  - bit0 = out_count==OUT_DEPTH
  - bit1 = out_drop sticky
  - bits[8 +: CW_OUT] = out_count
  - others 0.
- Input FIFO, push side:
  - net_ri = (in_count != IN_DEPTH), combinational from the registered count.
  - net_si=1 with not-full pushes net_di at tail.
  - net_si=1 while full: packet dropped, in_ovf<=1.
- Processor reads (nicEn=1, nicEnWr=0), d_out updated next edge (1-cycle latency):
  - addr 00, FIFO non-empty: d_out<=head, pop.
  - addr 00, FIFO empty: d_out<=0, no pop.
  - addr 01: d_out<=in-status. in_ovf cleared that same edge unless a new overflow occurs on that edge; a new overflow wins.
  - addr 10: d_out<=0 (write-only).
  - addr 11: d_out<=out-status. out_drop cleared with the same "new drop wins" rule.
  - Status reads reflect pre-edge values.
- Processor writes (nicEn=1, nicEnWr=1):
  - addr 10, not full: push d_in to output tail.
  - addr 10, full: write dropped, out_drop<=1.
  - Other addresses: ignored, no state change.
  - d_out<=0 on any write cycle.
- nicEn=0: d_out<=0, no processor-side state change.
- Output send:
  - net_so = (out_count!=0) && net_ro && (net_polarity==SEND_POL).
  - net_do = net_so ? head : 0.
  - On a clock edge with net_so=1, the head is popped.
- Fullness/emptiness for the push/pop decision is evaluated on registered count at cycle start.
  - Push into a full FIFO is dropped even if a pop occurs on the same edge.
  - Push and pop on a non-full, non-empty FIFO in the same cycle: count unchanged, both take effect.
  - Push into an empty FIFO is not visible to a pop until the next cycle (no fall-through).
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH and never over/underflows.
- Ordering is strict FIFO on both channels.
- Reset mid-operation: all buffered packets discarded, flags cleared, outputs to reset values on the next edge; in-flight net_si on the reset edge is ignored.

Test Plan:
- Reset check: assert reset 2 cycles, with net_si and nicEn toggling -> net_ri=1, net_so=0, net_do=0, d_out=0; read addr 01 and 11 after reset -> both 0.
- Input fill/overflow: push A1..A4 via net_si on consecutive cycles (IN_DEPTH=4) -> net_ri=0 after the 4th. Push A5 -> dropped. Read addr 01 -> 0x0403 (count 4, ovf, non-empty). Read addr 01 again -> 0x0401.
- Input order and empty read: read addr 00 five times -> d_out=A1,A2,A3,A4,0; net_ri=1 after the first pop; count ends 0.
- Output polarity gating: write B1,B2,B3 to addr 10 with net_ro=1 and net_polarity alternating 0/1 (SEND_POL=1) -> net_so only on polarity=1 cycles; net_do=B1,B2,B3 in order; net_do=0 otherwise.
- Output full/drop with simultaneous send: net_ro=0, write 5 packets -> 5th dropped; addr 11 reads 0x0403 (count 4, drop, full). Then raise net_ro with polarity=1 and write C on the same cycle -> C dropped, head sent, count 3.
- Simultaneous push/pop plus mid-op reset: the input FIFO holds 2 packets; net_si and an addr 00 read occur on the same cycle -> count stays 2, the oldest packet returned. Assert reset with 3 packets in each FIFO -> both counts 0, net_so=0, in-status reads 0.
